// File: rtl/dct_block_arbiter.sv
// -----------------------------------------------------------------------------
// dct_block_arbiter
//
// Shares one 8x8 2-D DCT engine (64-point flattened valid/ready interface)
// among NREQ block requesters. The input side is granted round-robin, every
// accepted block's requester ID is queued in an in-order tag FIFO, and each
// engine result is steered back to the requester at the FIFO head. Steering
// is purely combinational, so no pipeline latency is added in either
// direction.
//
// Optional build macro: DCT_ARB_STATS_EN
//   When defined, adds output stat_blocks (NREQ x 16-bit saturating counters
//   of results returned per requester). When undefined the port and the
//   counters are absent and everything else is identical.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       per-requester block valid                      [NREQ]
//   req_ready       per-requester block accepted                   [NREQ]
//   req_data        requester k at [k*64*IN_W +: 64*IN_W]          [NREQ*64*IN_W]
//   eng_in_valid    to engine in_valid
//   eng_in_ready    from engine in_ready
//   eng_in_data     to engine in_data                              [64*IN_W]
//   eng_out_valid   from engine out_valid
//   eng_out_ready   to engine out_ready
//   eng_out_data    from engine out_data                           [64*IN_W]
//   rsp_valid       one-hot result valid                           [NREQ]
//   rsp_ready       per-requester result ready                     [NREQ]
//   rsp_data        shared result bus (= eng_out_data)             [64*IN_W]
//   inflight        blocks accepted but not yet returned
//   stat_blocks     per-requester result counters (DCT_ARB_STATS_EN only)
//   err             sticky protocol error
// -----------------------------------------------------------------------------
module dct_block_arbiter #(
    parameter int NREQ         = 3,
    parameter int IN_W         = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ*64*IN_W-1:0]          req_data,
    output logic                             eng_in_valid,
    input  logic                             eng_in_ready,
    output logic [64*IN_W-1:0]               eng_in_data,
    input  logic                             eng_out_valid,
    output logic                             eng_out_ready,
    input  logic [64*IN_W-1:0]               eng_out_data,
    output logic [NREQ-1:0]                  rsp_valid,
    input  logic [NREQ-1:0]                  rsp_ready,
    output logic [64*IN_W-1:0]               rsp_data,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
`ifdef DCT_ARB_STATS_EN
    output logic [NREQ*16-1:0]               stat_blocks,
`endif
    output logic                             err
);

    localparam int BLK_W = 64 * IN_W;
    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int AW    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NREQ - 1)) ? '0 : id + 1'b1;
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q,     state_d;
    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [ID_W-1:0]   locked_id_q, locked_id_d;
    logic [CNT_W-1:0]  inflight_q,  inflight_d;
    logic [AW-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q,    rd_ptr_d;
    logic              err_q,       err_d;
    logic [ID_W-1:0]   tag_mem_q [MAX_INFLIGHT];

    logic              cand_found;
    logic [ID_W-1:0]   cand_id;
    logic [ID_W:0]     cand_idx;
    logic              grant;
    logic              push;
    logic [ID_W-1:0]   push_id;
    logic              pop;
    logic              lock_drop;
    logic              fifo_empty;
    logic [ID_W-1:0]   head_id;
    logic [ID_W-1:0]   sel_id;

    // ------------------------------------------------------------------
    // Round-robin candidate: first valid requester at or after rr_ptr_q.
    // ------------------------------------------------------------------
    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        cand_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (cand_idx >= (ID_W+1)'(NREQ)) begin
                cand_idx = cand_idx - (ID_W+1)'(NREQ);
            end
            if (!cand_found && req_valid[cand_idx[ID_W-1:0]]) begin
                cand_found = 1'b1;
                cand_id    = cand_idx[ID_W-1:0];
            end
        end
    end

    // The credit check uses the registered count only, so a pop in this
    // cycle cannot open a slot for a grant in the same cycle. rst_n is
    // included so no grant is presented while reset is held.
    assign grant = rst_n && (state_q == ST_ARB) && cand_found
                   && (inflight_q < CNT_W'(MAX_INFLIGHT));

    // ------------------------------------------------------------------
    // Grant FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        locked_id_d = locked_id_q;
        push        = 1'b0;
        push_id     = cand_id;
        lock_drop   = 1'b0;
        unique case (state_q)
            ST_ARB: begin
                if (grant) begin
                    if (eng_in_ready) begin
                        push     = 1'b1;
                        rr_ptr_d = next_id(cand_id);
                    end else begin
                        locked_id_d = cand_id;
                        state_d     = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                push_id = locked_id_q;
                if (!req_valid[locked_id_q]) begin
                    // Requester withdrew a block the engine had not taken.
                    lock_drop = 1'b1;
                    state_d   = ST_ARB;
                end else if (eng_in_ready) begin
                    push     = 1'b1;
                    rr_ptr_d = next_id(locked_id_q);
                    state_d  = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // ------------------------------------------------------------------
    // Grant FSM: outputs. While LOCKED only locked_id_q is driven, which
    // keeps eng_in_data stable until the engine accepts it.
    // ------------------------------------------------------------------
    always_comb begin
        req_ready    = '0;
        eng_in_valid = 1'b0;
        sel_id       = (state_q == ST_LOCKED) ? locked_id_q : cand_id;
        eng_in_data  = req_data[sel_id*BLK_W +: BLK_W];
        unique case (state_q)
            ST_ARB: begin
                if (grant) begin
                    eng_in_valid       = 1'b1;
                    req_ready[cand_id] = eng_in_ready;
                end
            end
            ST_LOCKED: begin
                eng_in_valid           = req_valid[locked_id_q];
                req_ready[locked_id_q] = eng_in_ready;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Return path and tag FIFO bookkeeping
    // ------------------------------------------------------------------
    assign fifo_empty = (inflight_q == '0);
    assign head_id    = tag_mem_q[rd_ptr_q];
    assign rsp_data   = eng_out_data;

    always_comb begin
        rsp_valid     = '0;
        eng_out_ready = 1'b0;
        if (!fifo_empty) begin
            rsp_valid[head_id] = eng_out_valid;
            eng_out_ready      = rsp_ready[head_id];
        end
        pop = eng_out_valid && eng_out_ready;

        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        inflight_d = inflight_q;
        if (push && !pop) begin
            inflight_d = inflight_q + 1'b1;
        end else if (pop && !push) begin
            inflight_d = inflight_q - 1'b1;
        end

        // A result with no tag to route it is an error, as is a dropped lock.
        err_d = err_q || lock_drop || (fifo_empty && eng_out_valid);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
            state_q     <= ST_ARB;
            rr_ptr_q    <= '0;
            locked_id_q <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            locked_id_q <= locked_id_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
        end
    end

    // NOTE: tag storage is deliberately not reset; occupancy is tracked by inflight_q, so stale entries are never consumed.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= push_id;
        end
    end

    assign inflight = inflight_q;
    assign err      = err_q;

`ifdef DCT_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Per-requester saturating result counters
    // ------------------------------------------------------------------
    logic [15:0] stat_q [NREQ];
    logic [15:0] stat_d [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            stat_d[i] = stat_q[i];
        end
        if (pop && (stat_q[head_id] != 16'hFFFF)) begin
            stat_d[head_id] = stat_q[head_id] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_blocks[g*16 +: 16] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_dct_block_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dct_block_arbiter
//
// Directed bench for dct_block_arbiter (NREQ=3, IN_W=32, MAX_INFLIGHT=4).
// A table of per-cycle records holds the inputs and the hand-computed
// outputs expected before the next rising edge; a hand-written sequence
// covers reset asserted while LOCKED and a result arriving after reset.
// -----------------------------------------------------------------------------
module tb_dct_block_arbiter;

    localparam int NREQ  = 3;
    localparam int IN_W  = 32;
    localparam int MAXI  = 4;
    localparam int BLK_W = 64 * IN_W;
    localparam int CNT_W = $clog2(MAXI + 1);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*BLK_W-1:0]   req_data = '0;
    logic                    eng_in_valid;
    logic                    eng_in_ready = 1'b0;
    logic [BLK_W-1:0]        eng_in_data;
    logic                    eng_out_valid = 1'b0;
    logic                    eng_out_ready;
    logic [BLK_W-1:0]        eng_out_data = '0;
    logic [NREQ-1:0]         rsp_valid;
    logic [NREQ-1:0]         rsp_ready = '0;
    logic [BLK_W-1:0]        rsp_data;
    logic [CNT_W-1:0]        inflight;
    logic                    err;
`ifdef DCT_ARB_STATS_EN
    logic [NREQ*16-1:0]      stat_blocks;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dct_block_arbiter #(
        .NREQ         (NREQ),
        .IN_W         (IN_W),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .eng_in_valid  (eng_in_valid),
        .eng_in_ready  (eng_in_ready),
        .eng_in_data   (eng_in_data),
        .eng_out_valid (eng_out_valid),
        .eng_out_ready (eng_out_ready),
        .eng_out_data  (eng_out_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .inflight      (inflight),
`ifdef DCT_ARB_STATS_EN
        .stat_blocks   (stat_blocks),
`endif
        .err           (err)
    );

    typedef struct {
        bit          rst;      // pulse reset before this vector
        logic [2:0]  rv;       // req_valid
        logic        eir;      // eng_in_ready
        logic        eov;      // eng_out_valid
        logic [2:0]  rr;       // rsp_ready
        logic [2:0]  x_rdy;    // expected req_ready
        logic        x_eiv;    // expected eng_in_valid
        logic        x_eor;    // expected eng_out_ready
        logic [2:0]  x_rspv;   // expected rsp_valid
        int          x_infl;   // expected inflight
        logic        x_err;    // expected err
        int          x_sel;    // requester whose block must be on eng_in_data, -1 = unchecked
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, logic [2:0] rv, logic eir, logic eov, logic [2:0] rr,
                                logic [2:0] x_rdy, logic x_eiv, logic x_eor, logic [2:0] x_rspv,
                                int x_infl, logic x_err, int x_sel);
        vec_t v;
        v.rst = rst;     v.rv = rv;       v.eir = eir;     v.eov = eov;   v.rr = rr;
        v.x_rdy = x_rdy; v.x_eiv = x_eiv; v.x_eor = x_eor; v.x_rspv = x_rspv;
        v.x_infl = x_infl; v.x_err = x_err; v.x_sel = x_sel;
        return v;
    endfunction

    // Distinct recognisable block per requester.
    function automatic logic [BLK_W-1:0] blk(int k);
        logic [BLK_W-1:0] b;
        for (int i = 0; i < 64; i++) begin
            b[i*IN_W +: IN_W] = 32'hA000_0000 + 32'(k * 256) + 32'(i);
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_blk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got word0 %0h word63 %0h expected word0 %0h word63 %0h at %0t",
                     name, act[31:0], act[BLK_W-1 -: 32], exp[31:0], exp[BLK_W-1 -: 32], $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        req_valid     = '0;
        eng_in_ready  = 1'b0;
        eng_out_valid = 1'b0;
        rsp_ready     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            req_data[k*BLK_W +: BLK_W] = blk(k);
        end

        //              rst rv    eir eov rr     | rdy    eiv eor rspv   infl err sel
        // Single requester, result returned next cycle.
        vecs.push_back(mk(1, 3'b001, 1, 0, 3'b000, 3'b001, 1, 0, 3'b000, 0, 0,  0));
        vecs.push_back(mk(0, 3'b000, 1, 1, 3'b001, 3'b000, 0, 1, 3'b001, 1, 0, -1));
        vecs.push_back(mk(0, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 0, -1));
        // Fairness 0,1,2,0; credit limit at 4; stalled, then released result.
        vecs.push_back(mk(1, 3'b111, 1, 0, 3'b000, 3'b001, 1, 0, 3'b000, 0, 0,  0));
        vecs.push_back(mk(0, 3'b111, 1, 0, 3'b000, 3'b010, 1, 0, 3'b000, 1, 0,  1));
        vecs.push_back(mk(0, 3'b111, 1, 0, 3'b000, 3'b100, 1, 0, 3'b000, 2, 0,  2));
        vecs.push_back(mk(0, 3'b111, 1, 0, 3'b000, 3'b001, 1, 0, 3'b000, 3, 0,  0));
        vecs.push_back(mk(0, 3'b111, 1, 1, 3'b000, 3'b000, 0, 0, 3'b001, 4, 0, -1));
        vecs.push_back(mk(0, 3'b111, 1, 1, 3'b111, 3'b000, 0, 1, 3'b001, 4, 0, -1));
        vecs.push_back(mk(0, 3'b111, 1, 1, 3'b111, 3'b010, 1, 1, 3'b010, 3, 0,  1));
        vecs.push_back(mk(0, 3'b000, 1, 1, 3'b111, 3'b000, 0, 1, 3'b100, 3, 0, -1));
        vecs.push_back(mk(0, 3'b000, 1, 1, 3'b111, 3'b000, 0, 1, 3'b001, 2, 0, -1));
        vecs.push_back(mk(0, 3'b000, 1, 1, 3'b111, 3'b000, 0, 1, 3'b010, 1, 0, -1));
        vecs.push_back(mk(0, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 0, -1));
        // Engine backpressure for 5 cycles, locked on requester 1.
        vecs.push_back(mk(1, 3'b110, 0, 0, 3'b000, 3'b000, 1, 0, 3'b000, 0, 0,  1));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(0, 3'b110, 0, 0, 3'b000, 3'b000, 1, 0, 3'b000, 0, 0,  1));
        end
        vecs.push_back(mk(0, 3'b110, 1, 0, 3'b000, 3'b010, 1, 0, 3'b000, 0, 0,  1));
        vecs.push_back(mk(0, 3'b100, 1, 0, 3'b000, 3'b100, 1, 0, 3'b000, 1, 0,  2));
        // Response stall on the head requester; others' ready must not pop it.
        vecs.push_back(mk(0, 3'b000, 1, 1, 3'b101, 3'b000, 0, 0, 3'b010, 2, 0, -1));
        vecs.push_back(mk(0, 3'b000, 1, 1, 3'b010, 3'b000, 0, 1, 3'b010, 2, 0, -1));
        vecs.push_back(mk(0, 3'b000, 1, 1, 3'b001, 3'b000, 0, 0, 3'b100, 1, 0, -1));
        vecs.push_back(mk(0, 3'b000, 1, 1, 3'b100, 3'b000, 0, 1, 3'b100, 1, 0, -1));
        vecs.push_back(mk(0, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 0, -1));
        // Result with empty tag FIFO -> sticky err.
        vecs.push_back(mk(0, 3'b000, 1, 1, 3'b111, 3'b000, 0, 0, 3'b000, 0, 0, -1));
        vecs.push_back(mk(0, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 1, -1));
        vecs.push_back(mk(0, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 1, -1));
        // Locked requester drops valid -> err, back to arbitration.
        vecs.push_back(mk(1, 3'b001, 0, 0, 3'b000, 3'b000, 1, 0, 3'b000, 0, 0,  0));
        vecs.push_back(mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 0, -1));
        vecs.push_back(mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 1, -1));
        vecs.push_back(mk(0, 3'b010, 1, 0, 3'b000, 3'b010, 1, 0, 3'b000, 0, 1,  1));

        do_reset();
        @(negedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_eng_in_valid", 32'(eng_in_valid), 32'h0);
        check("reset_inflight", 32'(inflight), 32'h0);
        check("reset_err", 32'(err), 32'h0);

        foreach (vecs[n]) begin
            if (vecs[n].rst) do_reset();
            @(negedge clk);
            req_valid     = vecs[n].rv;
            eng_in_ready  = vecs[n].eir;
            eng_out_valid = vecs[n].eov;
            rsp_ready     = vecs[n].rr;
            eng_out_data  = {64{32'hD000_0000 + 32'(n)}};
            #1;
            check($sformatf("v%0d_req_ready", n),     32'(req_ready),     32'(vecs[n].x_rdy));
            check($sformatf("v%0d_eng_in_valid", n),  32'(eng_in_valid),  32'(vecs[n].x_eiv));
            check($sformatf("v%0d_eng_out_ready", n), 32'(eng_out_ready), 32'(vecs[n].x_eor));
            check($sformatf("v%0d_rsp_valid", n),     32'(rsp_valid),     32'(vecs[n].x_rspv));
            check($sformatf("v%0d_inflight", n),      32'(inflight),      32'(vecs[n].x_infl));
            check($sformatf("v%0d_err", n),           32'(err),           32'(vecs[n].x_err));
            check_blk($sformatf("v%0d_rsp_data", n), rsp_data, {64{32'hD000_0000 + 32'(n)}});
            if (vecs[n].x_sel >= 0) begin
                check_blk($sformatf("v%0d_eng_in_data", n), eng_in_data, blk(vecs[n].x_sel));
            end
        end

        // Reset asserted while LOCKED with a block outstanding and err set.
        @(negedge clk);
        req_valid = 3'b001; eng_in_ready = 1'b1; eng_out_valid = 1'b0; rsp_ready = '0;
        #1;
        check("h_accept_req_ready", 32'(req_ready), 32'h1);
        check("h_accept_inflight", 32'(inflight), 32'h1);
        @(negedge clk);
        req_valid = 3'b001; eng_in_ready = 1'b0;
        #1;
        check("h_lock_eng_in_valid", 32'(eng_in_valid), 32'h1);
        check("h_lock_inflight", 32'(inflight), 32'h2);
        @(negedge clk);
        #1;
        check("h_locked_eng_in_valid", 32'(eng_in_valid), 32'h1);
        check_blk("h_locked_eng_in_data", eng_in_data, blk(0));
        check("h_locked_err", 32'(err), 32'h1);
        rst_n = 1'b0; eng_out_valid = 1'b1; rsp_ready = 3'b111;
        #1;
        check("h_rst_req_ready", 32'(req_ready), 32'h0);
        check("h_rst_eng_in_valid", 32'(eng_in_valid), 32'h0);
        check("h_rst_eng_out_ready", 32'(eng_out_ready), 32'h0);
        check("h_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("h_rst_inflight", 32'(inflight), 32'h0);
        check("h_rst_err", 32'(err), 32'h0);
        // Release reset while a stale result is still presented.
        @(negedge clk);
        req_valid = '0; rst_n = 1'b1;
        #1;
        check("h_post_eng_out_ready", 32'(eng_out_ready), 32'h0);
        check("h_post_err_before", 32'(err), 32'h0);
        @(negedge clk);
        eng_out_valid = 1'b0;
        #1;
        check("h_post_err_after", 32'(err), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct_block_arbiter.md
Name: dct_block_arbiter

Overview:
- Shares one 8x8 2-D DCT engine (64-point flattened valid/ready interface) among NREQ block requesters, e.g. the Y, Cb and Cr block feeders.
- Round-robin grant on the engine input side.
- Records the requester ID of every accepted block in an in-order tag FIFO.
- Steers each engine result back to the requester that issued it.
- Sits between the block-assembly stage and the DCT engine; adds no pipeline latency.

Parameters:
- NREQ, 3, number of requesters (2..8)
- IN_W, 32, bits per coefficient/pixel; must match the engine
- MAX_INFLIGHT, 4, tag FIFO depth = max blocks accepted but not yet returned (power of 2, >=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester block valid
- req_ready  out  NREQ  per-requester block accepted
- req_data  in  NREQ*64*IN_W  requester k occupies slice [k*64*IN_W +: 64*IN_W]
- eng_in_valid  out  1  to engine in_valid
- eng_in_ready  in  1  from engine in_ready
- eng_in_data  out  64*IN_W  to engine in_data
- eng_out_valid  in  1  from engine out_valid
- eng_out_ready  out  1  to engine out_ready
- eng_out_data  in  64*IN_W  from engine out_data
- rsp_valid  out  NREQ  one-hot result valid
- rsp_ready  in  NREQ  per-requester result ready
- rsp_data  out  64*IN_W  shared result bus (= eng_out_data)
- inflight  out  $clog2(MAX_INFLIGHT+1)  blocks outstanding
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, while rst_n=0):
  - rr_ptr=0, state=ARB, locked_id=0, tag FIFO empty, inflight=0, err=0.
  - Consequently req_ready=0, eng_in_valid=0, eng_out_ready=0, rsp_valid=0.
  - Reset mid-operation discards all tags; results emerging afterwards are handled by the error rule below.
- Grant FSM, two states:
  - ARB:
    - Candidate = first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, … modulo NREQ.
    - Grant only if inflight < MAX_INFLIGHT, using the registered count; a same-cycle pop does not free a slot for a same-cycle grant.
    - With a grant: eng_in_valid=1, eng_in_data = req_data slice of the candidate, req_ready[candidate]=eng_in_ready.
    - If eng_in_ready=1: transfer. Push the candidate ID, rr_ptr<=candidate+1 (mod NREQ), stay in ARB.
    - If eng_in_ready=0: locked_id<=candidate, go to LOCKED.
  - LOCKED:
    - Drive locked_id only: eng_in_valid=req_valid[locked_id], req_ready[locked_id]=eng_in_ready. No re-arbitration, so eng_in_data is stable until accepted.
    - On transfer: push locked_id, rr_ptr<=locked_id+1, go to ARB.
    - If the requester drops valid (protocol violation): set err, go to ARB.
  - All req_ready bits of non-granted requesters are 0.
- Return path:
  - If FIFO non-empty with head h: rsp_valid[h]=eng_out_valid, eng_out_ready=rsp_ready[h], rsp_data=eng_out_data.
  - Pop when eng_out_valid & eng_out_ready.
  - If FIFO empty: eng_out_ready=0, rsp_valid=0. If eng_out_valid=1 here, set err (result without tag).
- inflight:
  - +1 on push, -1 on pop, unchanged on simultaneous push and pop.
  - Never exceeds MAX_INFLIGHT or goes below 0.
- Latency: zero cycles in both directions (combinational steering); grant and rr_ptr take effect the cycle after a transfer.
- Ordering: results return in acceptance order. The engine is in-order, so the FIFO head always matches.
- err stays 1 until reset.

Optional Feature:
- Macro: DCT_ARB_STATS_EN.
- Defined:
  - Adds output stat_blocks, NREQ*16 bits.
  - One 16-bit counter per requester, incremented on each pop for that ID.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined:
  - The port and the counters are absent.
  - All other behaviour is identical.

Test Plan:
- Single requester: req_valid=3'b001 for 1 block, engine always ready -> req_ready[0]=1 in the same cycle, inflight=1. When the result returns: rsp_valid=3'b001, rsp_data equals the engine output, inflight=0.
- Fairness: all 3 requesters continuously valid, engine always ready, MAX_INFLIGHT=4 -> grant order 0,1,2,0,1,2. Results return with rsp_valid 001,010,100,001,… in the same order.
- Engine backpressure: eng_in_ready=0 for 5 cycles while req 1 and req 2 are valid -> LOCKED on req 1. eng_in_data is unchanged for all 5 cycles, req_ready stays 0, and req 1 is accepted when ready rises.
- Credit limit: MAX_INFLIGHT=2, engine output stalled (rsp_ready=0) -> after 2 accepts, eng_in_valid=0 and inflight=2. Asserting rsp_ready pops one, and the next grant occurs one cycle later.
- Response stall: head ID=2 with rsp_ready[2]=0 and rsp_ready[0]=1 -> eng_out_ready=0 and the result is held. rsp_ready[2]=1 -> pop.
- Error/reset: eng_out_valid=1 with an empty FIFO -> err=1 and sticky. Assert rst_n=0 mid-LOCKED -> all outputs 0 immediately, err=0, inflight=0.
